// File: rtl/game_round_pkg.sv
// Shared types and helpers for the game round controller.
package game_round_pkg;

   localparam int unsigned PHASE_WIDTH = 2;

   typedef enum logic [PHASE_WIDTH-1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      PLAY      = 2'd2,
      END       = 2'd3
   } phase_t;

   // Duration loaded into game_timer when a timed phase is entered; IDLE has no timer.
   function automatic int unsigned phase_ticks(input phase_t p,
                                               input int unsigned countdown_ticks,
                                               input int unsigned round_ticks,
                                               input int unsigned end_ticks);
      int unsigned ticks;
      ticks = 0;
      case (p)
         COUNTDOWN: ticks = countdown_ticks;
         PLAY:      ticks = round_ticks;
         END:       ticks = end_ticks;
         default:   ticks = 0;
      endcase
      return ticks;
   endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// Load/run handshake between the round controller and game_timer.
interface game_round_controller_if #(
   parameter int unsigned TIMER_WIDTH = 32
);
   logic                   timer_start;
   logic [TIMER_WIDTH-1:0] timer_value;
   logic                   timer_running;

   modport master (output timer_start, output timer_value, input timer_running);
   modport slave  (input timer_start, input timer_value, output timer_running);
endinterface

// File: rtl/game_edge_detect.sv
// Registered rising-edge detector for a synchronised level input.
module game_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise_c
);

   logic level_q;

   // Remember the previous level so a held input yields a single edge.
   always_ff @(posedge clk) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign rise_c = level & ~level_q;

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer upstream of game_timer: IDLE -> COUNTDOWN -> PLAY -> END -> IDLE.
// Optional best-score tracking is enabled by defining GAME_ROUND_BEST_SCORE_EN.
module game_round_controller
   import game_round_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH     = 32,
   parameter int unsigned COUNTDOWN_TICKS = 50_000_000,
   parameter int unsigned ROUND_TICKS     = 500_000_000,
   parameter int unsigned END_TICKS       = 100_000_000,
   parameter int unsigned SCORE_WIDTH     = 8,
   parameter int unsigned WIN_SCORE       = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       launch,
   input  logic                       hit,
   game_round_controller_if.master    tmr,
   output logic [PHASE_WIDTH-1:0]     phase,
   output logic [SCORE_WIDTH-1:0]     score,
   output logic                       round_over,
   output logic                       game_won,
   output logic [SCORE_WIDTH-1:0]     best_score
);

   phase_t                 state, state_d;
   logic                   launch_rise_c, hit_rise_c;
   logic                   start_q, start_d;
   logic [TIMER_WIDTH-1:0] value_q, value_d;
   logic                   armed_q, armed_d;
   logic [SCORE_WIDTH-1:0] score_d, score_inc_c;
   logic                   won_d, round_over_d;
   logic                   expire_c, win_c, enter_timed_c;

   game_edge_detect u_launch_edge (
      .clk    (clk),
      .reset  (reset),
      .level  (launch),
      .rise_c (launch_rise_c)
   );

   game_edge_detect u_hit_edge (
      .clk    (clk),
      .reset  (reset),
      .level  (hit),
      .rise_c (hit_rise_c)
   );

   // Timer has stopped after being seen running; never trusted in the start cycle.
   assign expire_c    = armed_q & ~tmr.timer_running & ~start_q;
   assign score_inc_c = (score == '1) ? score : score + SCORE_WIDTH'(1);
   assign win_c       = (score_inc_c == SCORE_WIDTH'(WIN_SCORE));

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         value_q    <= '0;
         armed_q    <= 1'b0;
         score      <= '0;
         game_won   <= 1'b0;
         round_over <= 1'b0;
      end else begin
         state      <= state_d;
         start_q    <= start_d;
         value_q    <= value_d;
         armed_q    <= armed_d;
         score      <= score_d;
         game_won   <= won_d;
         round_over <= round_over_d;
      end
   end

   // Phase transitions; a winning hit cuts PLAY short even while the timer runs.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:      if (launch_rise_c) state_d = COUNTDOWN;
         COUNTDOWN: if (expire_c) state_d = PLAY;
         PLAY:      if ((hit_rise_c && win_c) || expire_c) state_d = END;
         END:       if (expire_c) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the chosen transition.
   always_comb begin
      enter_timed_c = (state_d != state) && (state_d != IDLE);
      start_d       = enter_timed_c;
      value_d       = value_q;
      armed_d       = armed_q;
      score_d       = score;
      won_d         = game_won;
      round_over_d  = (state == PLAY) && (state_d == END);

      if (enter_timed_c)
         value_d = TIMER_WIDTH'(phase_ticks(state_d, COUNTDOWN_TICKS, ROUND_TICKS, END_TICKS));

      if (enter_timed_c)
         armed_d = 1'b0;
      else if (!start_q && tmr.timer_running)
         armed_d = 1'b1;

      if (state == IDLE && launch_rise_c) begin
         score_d = '0;
         won_d   = 1'b0;
      end

      if (state == PLAY && hit_rise_c) begin
         score_d = score_inc_c;
         if (win_c) won_d = 1'b1;
      end
   end

   assign tmr.timer_start = start_q;
   assign tmr.timer_value = value_q;
   assign phase           = state;

`ifdef GAME_ROUND_BEST_SCORE_EN
   logic [SCORE_WIDTH-1:0] best_q, best_d;

   // Fold the final round score (including a winning hit) into the best score.
   always_comb begin
      best_d = best_q;
      if (round_over_d && (score_d > best_q)) best_d = score_d;
   end

   // Best score survives rounds; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) best_q <= '0;
      else       best_q <= best_d;
   end

   assign best_score = best_q;
`else
   assign best_score = '0;
`endif

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Round sequencer sitting directly upstream of game_timer in the lab game.
- Steps a round through IDLE -> COUNTDOWN -> PLAY -> END -> IDLE.
- Loads game_timer with per-phase durations via a one-cycle start pulse and advances when the timer stops running.
- Counts hits from the collision logic during PLAY and ends the round early on a win.

Parameters:
- TIMER_WIDTH, 32, width of timer_value; matches game_timer width.
- COUNTDOWN_TICKS, 50_000_000, clk cycles loaded for COUNTDOWN.
- ROUND_TICKS, 500_000_000, clk cycles loaded for PLAY.
- END_TICKS, 100_000_000, clk cycles loaded for END.
- SCORE_WIDTH, 8, width of score.
- WIN_SCORE, 10, score that ends PLAY with a win; must be in 1..2^SCORE_WIDTH-1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- launch  input  1  level from start key, synchronised; rising edge starts a round
- hit  input  1  level from collision detector; rising edge counts one hit
- timer_running  input  1  running output of game_timer
- timer_start  output  1  one-cycle load pulse to game_timer
- timer_value  output  TIMER_WIDTH  duration presented with timer_start
- phase  output  2  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 END
- score  output  SCORE_WIDTH  hits in current round
- round_over  output  1  one-cycle pulse on entry to END
- game_won  output  1  set on entry to END if WIN_SCORE reached; holds until next launch
- best_score  output  SCORE_WIDTH  best round score (optional feature)

Behaviour:
- Reset: phase=IDLE; score, timer_start, timer_value, round_over, game_won, best_score, armed flag and edge registers all 0.
- All outputs are registered. Edge detect: edge = in & ~in_q, with in_q registered.
- Timed-state entry at edge N:
  - phase, timer_start=1 and timer_value=<phase ticks> are all registered at edge N.
  - timer_start deasserts at edge N+1.
  - armed is cleared at edge N.
- armed is set at any edge where timer_start=0 and timer_running=1.
- expire = armed & ~timer_running & ~timer_start. The controller never acts on timer_running in the start cycle.
- IDLE:
  - launch edge -> COUNTDOWN (COUNTDOWN_TICKS); score<=0, game_won<=0.
  - hit is ignored.
- COUNTDOWN:
  - expire -> PLAY (ROUND_TICKS).
  - launch and hit are ignored.
- PLAY:
  - hit edge: score<=score+1, saturating at all-ones.
  - If score+1 == WIN_SCORE on a hit edge: go to END (END_TICKS) in the same edge, game_won<=1. The reload start overrides the still-running timer.
  - Else expire -> END (END_TICKS), game_won stays 0.
  - If a hit edge and expire occur in the same cycle, the hit is counted first; the win check uses the incremented score.
  - round_over<=1 on entry to END, for one cycle.
- END:
  - expire -> IDLE, with no timer start.
  - launch is ignored until IDLE.
- A launch held high across entry to IDLE does not restart a round; a new rising edge is required.
- Reset mid-round returns to IDLE immediately. game_timer is reset by the same reset.

Optional Feature:
- Macro: GAME_ROUND_BEST_SCORE_EN.
- Defined: best_score updates on entry to END to max(best_score, final score, including the winning hit). It is cleared only by reset.
- Undefined: best_score is tied to 0 and no register is inferred.

Decomposition:
- Package game_round_pkg holds:
  - phase_t enum (IDLE=2'd0, COUNTDOWN=2'd1, PLAY=2'd2, END=2'd3).
  - Phase-to-ticks selection function.
- Sub-module game_edge_detect (registered rising-edge detector) is used twice, for launch and hit.

Test Plan:
Bench setup: COUNTDOWN_TICKS=3, ROUND_TICKS=20, END_TICKS=4, WIN_SCORE=3, with a behavioural game_timer model.
- Reset, then 10 idle cycles -> phase=0, timer_start never asserted, all outputs 0.
- launch edge -> next edge phase=1 with timer_start=1 and timer_value=3. After expire: phase=2 with timer_value=20. After expire: phase=3, round_over one cycle, game_won=0. After expire: phase=0.
- In PLAY, 3 hit edges 2 cycles apart -> score 1,2,3. On the third hit: phase=3, game_won=1, timer_start=1 with timer_value=4 while the timer is still running.
- hit edge in the same cycle as PLAY expire with score=1 -> score=2, phase=3, game_won=0. hit edges during IDLE, COUNTDOWN and END leave score unchanged.
- launch held high through an entire round -> returns to IDLE and stays. launch pulses during PLAY are ignored.
- Reset asserted mid-PLAY with score=2 -> IDLE, score=0, timer_start=0. With GAME_ROUND_BEST_SCORE_EN: rounds scoring 2 then 1 -> best_score=2.
